// File: rtl/interrupt_controller.sv
// Multi-source interrupt controller: pending/mask bits, fixed priority (lowest index wins),
// time-slice timer, and saved-PC/cause registers that drive the PC redirect to the OS vector.
module interrupt_controller #(
  parameter int                   NUM_SRC     = 4,
  parameter int                   PC_WIDTH    = 11,
  parameter int                   TIMER_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]  VECTOR_PC   = '0,
  parameter logic [NUM_SRC-1:0]   MASK_RESET  = '1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_SRC-1:0]     i_irq_in,
  input  logic                   i_halt,
  input  logic                   i_set_timer,
  input  logic [TIMER_WIDTH-1:0] i_timer_value,
  input  logic                   i_mask_wr,
  input  logic [NUM_SRC-1:0]     i_mask_data,
  input  logic                   i_ack,
  input  logic [PC_WIDTH-1:0]    i_pc_next,
  output logic                   o_take,
  output logic [PC_WIDTH-1:0]    o_vector_pc,
  output logic [PC_WIDTH-1:0]    o_saved_pc,
  output logic [31:0]            o_cause,
  output logic [NUM_SRC-1:0]     o_pending,
  output logic [NUM_SRC-1:0]     o_mask,
  output logic                   o_in_service
);

  localparam int IDX_W = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1;
  // Lines 0 and 1 are internal sources; only external lines feed the edge detector.
  localparam logic [NUM_SRC-1:0] EXT_MASK = ~(NUM_SRC'(3));

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SERVICE = 1'b1} state_t;

  state_t                 r_state, w_state_next;
  logic [NUM_SRC-1:0]     r_pending, w_pending_next;
  logic [NUM_SRC-1:0]     r_mask;
  logic [NUM_SRC-1:0]     r_irq_prev;
  logic [PC_WIDTH-1:0]    r_saved_pc, w_saved_pc_next;
  logic [31:0]            r_cause, w_cause_next;
  logic [TIMER_WIDTH-1:0] r_timer, w_timer_next;

  logic [NUM_SRC-1:0]     w_irq_ext;
  logic [NUM_SRC-1:0]     w_set;
  logic [NUM_SRC-1:0]     w_eligible;
  logic [NUM_SRC-1:0]     w_clear;
  logic [IDX_W-1:0]       w_winner;
  logic                   w_timer_fire;
  logic                   w_take;

  assign w_irq_ext  = i_irq_in & EXT_MASK;
  assign w_eligible = r_pending & r_mask;

  // Timer: a load overrides both decrement and expiry; counting only while IDLE.
  always_comb begin
    w_timer_next = r_timer;
    w_timer_fire = 1'b0;
    if (i_set_timer) begin
      w_timer_next = i_timer_value;
    end else if ((r_state == S_IDLE) && (r_timer != '0)) begin
      w_timer_next = r_timer - TIMER_WIDTH'(1);
      w_timer_fire = (r_timer == TIMER_WIDTH'(1));
    end else begin
      w_timer_next = r_timer;
    end
  end

  assign w_set = (w_irq_ext & ~r_irq_prev) | NUM_SRC'({w_timer_fire, i_halt});

  // Lowest eligible index wins; scanning downward leaves the lowest match last.
  always_comb begin
    w_winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_winner = IDX_W'(i);
      end else begin
        w_winner = w_winner;
      end
    end
  end

  // FSM next state, take decision and capture values.
  always_comb begin
    w_state_next    = r_state;
    w_take          = 1'b0;
    w_cause_next    = r_cause;
    w_saved_pc_next = r_saved_pc;
    w_clear         = '0;
    case (r_state)
      S_IDLE: begin
        if ((|w_eligible) && !i_rst) begin
          w_take          = 1'b1;
          w_state_next    = S_SERVICE;
          w_cause_next    = 32'(w_winner) + 32'd1;
          w_saved_pc_next = i_pc_next;
          w_clear         = NUM_SRC'(1) << w_winner;
        end else begin
          w_take = 1'b0;
        end
      end
      S_SERVICE: begin
        if (i_ack) begin
          w_state_next = S_IDLE;
          w_cause_next = 32'd0;
        end else begin
          w_state_next = S_SERVICE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cause_next = 32'd0;
      end
    endcase
  end

  // A set event in the same cycle as the clear leaves the bit pending.
  assign w_pending_next = (r_pending & ~w_clear) | w_set;

  // State and data registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_pending  <= '0;
      r_mask     <= MASK_RESET;
      r_irq_prev <= '0;
      r_saved_pc <= '0;
      r_cause    <= 32'd0;
      r_timer    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_pending  <= w_pending_next;
      r_mask     <= i_mask_wr ? i_mask_data : r_mask;
      r_irq_prev <= w_irq_ext;
      r_saved_pc <= w_saved_pc_next;
      r_cause    <= w_cause_next;
      r_timer    <= w_timer_next;
    end
  end

  assign o_take       = w_take;
  assign o_vector_pc  = VECTOR_PC;
  assign o_saved_pc   = r_saved_pc;
  assign o_cause      = r_cause;
  assign o_pending    = r_pending;
  assign o_mask       = r_mask;
  assign o_in_service = (r_state == S_SERVICE);

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed-vector bench for interrupt_controller with hand-computed expectations.
module tb_interrupt_controller;

  logic        clk;
  logic        rst;
  logic [3:0]  irq_in;
  logic        halt;
  logic        set_timer;
  logic [15:0] timer_value;
  logic        mask_wr;
  logic [3:0]  mask_data;
  logic        ack;
  logic [10:0] pc_next;
  logic        take;
  logic [10:0] vector_pc;
  logic [10:0] saved_pc;
  logic [31:0] cause;
  logic [3:0]  pending;
  logic [3:0]  mask;
  logic        in_service;

  int n_cmp = 0;
  int n_bad = 0;

  interrupt_controller dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_irq_in     (irq_in),
    .i_halt       (halt),
    .i_set_timer  (set_timer),
    .i_timer_value(timer_value),
    .i_mask_wr    (mask_wr),
    .i_mask_data  (mask_data),
    .i_ack        (ack),
    .i_pc_next    (pc_next),
    .o_take       (take),
    .o_vector_pc  (vector_pc),
    .o_saved_pc   (saved_pc),
    .o_cause      (cause),
    .o_pending    (pending),
    .o_mask       (mask),
    .o_in_service (in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq_in = 4'b0000; halt = 1'b0; set_timer = 1'b0; timer_value = 16'd0;
    mask_wr = 1'b0; mask_data = 4'b0000; ack = 1'b0; pc_next = 11'h000;

    // Reset state
    #12;
    chk("rst_take", 32'(take), 32'd0);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_mask", 32'(mask), 32'hF);
    chk("rst_cause", cause, 32'd0);
    chk("rst_saved_pc", 32'(saved_pc), 32'h0);
    chk("rst_in_service", 32'(in_service), 32'd0);
    chk("vector_pc", 32'(vector_pc), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Timer quantum of 5 expires after 5 IDLE edges
    set_timer = 1'b1; timer_value = 16'd5; pc_next = 11'h020;
    tick();
    set_timer = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("tmr_pending_early", 32'(pending), 32'h0);
    chk("tmr_take_early", 32'(take), 32'd0);
    tick();
    chk("tmr_pending", 32'(pending), 32'h2);
    chk("tmr_take", 32'(take), 32'd1);
    tick();
    chk("tmr_cause", cause, 32'd2);
    chk("tmr_saved_pc", 32'(saved_pc), 32'h020);
    chk("tmr_in_service", 32'(in_service), 32'd1);
    chk("tmr_take_svc", 32'(take), 32'd0);
    do_ack();
    chk("tmr_ack_cause", cause, 32'd0);
    chk("tmr_ack_idle", 32'(in_service), 32'd0);

    // Halt and irq[2] edge together: halt first, then back-to-back irq[2]
    halt = 1'b1; irq_in = 4'b0100; pc_next = 11'h07F;
    chk("hi_take_before", 32'(take), 32'd0);
    tick();
    halt = 1'b0;
    chk("hi_pending", 32'(pending), 32'h5);
    chk("hi_take", 32'(take), 32'd1);
    tick();
    chk("hi_cause1", cause, 32'd1);
    chk("hi_saved_pc", 32'(saved_pc), 32'h07F);
    chk("hi_pending_after", 32'(pending), 32'h4);
    chk("hi_take_svc", 32'(take), 32'd0);
    do_ack();
    chk("hi_b2b_take", 32'(take), 32'd1);
    chk("hi_b2b_cause0", cause, 32'd0);
    pc_next = 11'h100;
    tick();
    chk("hi_cause3", cause, 32'd3);
    chk("hi_saved_pc2", 32'(saved_pc), 32'h100);
    chk("hi_pending_clr", 32'(pending), 32'h0);
    irq_in = 4'b0000;
    do_ack();

    // Masked request is held, taken once unmasked (mask write lands next edge)
    mask_wr = 1'b1; mask_data = 4'b1011;
    tick();
    mask_wr = 1'b0;
    chk("msk_mask", 32'(mask), 32'hB);
    irq_in = 4'b0100;
    tick();
    chk("msk_pending", 32'(pending), 32'h4);
    chk("msk_take_masked", 32'(take), 32'd0);
    mask_wr = 1'b1; mask_data = 4'b1111;
    chk("msk_take_oldmask", 32'(take), 32'd0);
    tick();
    mask_wr = 1'b0;
    chk("msk_mask_new", 32'(mask), 32'hF);
    chk("msk_take", 32'(take), 32'd1);
    tick();
    chk("msk_cause", cause, 32'd3);
    irq_in = 4'b0000;
    do_ack();

    // Accumulation in SERVICE: no nesting, then priority order on ack
    halt = 1'b1;
    tick();
    halt = 1'b0;
    tick();
    chk("acc_cause_first", cause, 32'd1);
    irq_in = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      halt = (i == 4);
      tick();
    end
    halt = 1'b0;
    chk("acc_pending", 32'(pending), 32'h9);
    chk("acc_take", 32'(take), 32'd0);
    chk("acc_in_service", 32'(in_service), 32'd1);
    irq_in = 4'b0000;
    do_ack();
    chk("acc_take_idle", 32'(take), 32'd1);
    tick();
    chk("acc_cause_halt", cause, 32'd1);
    chk("acc_pending_ext", 32'(pending), 32'h8);
    do_ack();
    tick();
    chk("acc_cause_ext3", cause, 32'd4);
    chk("acc_pending_none", 32'(pending), 32'h0);
    do_ack();

    // Reload with 0 on the expiry edge: load wins, timer stays silent
    set_timer = 1'b1; timer_value = 16'd1;
    tick();
    timer_value = 16'd0;
    tick();
    set_timer = 1'b0;
    chk("tz_pending", 32'(pending), 32'h0);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("tz_take", 32'(take), 32'd0);
    end

    // Asynchronous reset in the middle of SERVICE
    set_timer = 1'b1; timer_value = 16'd1; pc_next = 11'h155;
    tick();
    set_timer = 1'b0;
    tick();
    tick();
    chk("ar_cause_pre", cause, 32'd2);
    chk("ar_saved_pc_pre", 32'(saved_pc), 32'h155);
    #2 rst = 1'b1;
    #1;
    chk("ar_pending", 32'(pending), 32'h0);
    chk("ar_cause", cause, 32'd0);
    chk("ar_saved_pc", 32'(saved_pc), 32'h0);
    chk("ar_in_service", 32'(in_service), 32'd0);
    chk("ar_mask", 32'(mask), 32'hF);
    chk("ar_take", 32'(take), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
Parametrised multi-source interrupt controller for the single-cycle MIPS core. It generalises the fixed halt/clock-quantum interruption logic to NUM_SRC sources, adding:
- per-source pending and mask bits
- fixed priority
- a programmable time-slice timer
- saved-PC and cause registers

It drives the PC redirect to the OS vector and supplies the saved PC and cause to the write-back path for the get-interruption and save-PC-buffer instructions.

Parameters:
NUM_SRC, 4, number of interrupt sources (min 2); index 0 = halt, 1 = timer, 2..NUM_SRC-1 = external (keyboard, button, ...)
PC_WIDTH, 11, instruction address width
TIMER_WIDTH, 16, quantum counter width
VECTOR_PC, 0, PC value forced on interrupt take
MASK_RESET, all ones, mask register value after reset

Ports:
Clock  input  1  CPU clock; all state updates on rising edge
Reset  input  1  asynchronous, active-high reset
irq_in  input  NUM_SRC  external request lines; bits 0 and 1 ignored; rising edge detected internally
halt  input  1  halt instruction decoded this cycle
set_timer  input  1  load quantum from timer_value
timer_value  input  TIMER_WIDTH  quantum in cycles; 0 disables timer
mask_wr  input  1  write mask register
mask_data  input  NUM_SRC  new mask (1 = enabled)
ack  input  1  get-interruption: service finished, return to IDLE
pc_next  input  PC_WIDTH  PC the core would load this cycle
take  output  1  redirect PC to vector_pc this cycle (combinational)
vector_pc  output  PC_WIDTH  constant VECTOR_PC
saved_pc  output  PC_WIDTH  pc_next captured at last take
cause  output  32  0 = none, k+1 = source k in service
pending  output  NUM_SRC  pending register
mask  output  NUM_SRC  mask register
in_service  output  1  state == SERVICE

Behaviour:
- Reset (async): state IDLE, pending 0, mask MASK_RESET, saved_pc 0, cause 0, timer counter 0, edge-detect history 0. take = 0 while Reset is high.
- Pending set events:
  - halt sets pending[0].
  - Timer expiry sets pending[1].
  - A rising edge of irq_in[k], k ≥ 2, sets pending[k]. Edge means irq_in[k]=1 while the previous-cycle sample was 0.
  - Setting an already-set bit has no further effect; there is no counting.
- Eligible = pending & mask.
- FSM IDLE:
  - take = |eligible, combinational, same cycle.
  - Winner = lowest eligible index.
  - On that edge: saved_pc <= pc_next, cause <= winner+1, pending[winner] cleared, state <= SERVICE.
  - If a new set event for the winner occurs in the same cycle, the set wins and the bit stays 1.
- FSM SERVICE:
  - take = 0; no nesting.
  - Pending bits continue to accumulate.
  - ack -> IDLE next edge and cause <= 0. saved_pc holds.
- ack in IDLE is ignored.
- An eligible request in the first IDLE cycle after ack is taken immediately, so back-to-back service is allowed.
- Masked pending bits are retained and become eligible when unmasked.
- mask_wr takes effect on the next edge; take in the same cycle uses the old mask.
- Timer:
  - set_timer loads counter <= timer_value.
  - The counter decrements by 1 per cycle only in IDLE when nonzero.
  - The transition 1 -> 0 sets pending[1] on that edge.
  - The counter freezes in SERVICE; it is not auto-reloaded.
  - set_timer in the same cycle as expiry: the load wins and no expiry is flagged.
  - A counter of 0 never fires.
- Priority: halt (0) > timer (1) > externals in ascending index.
- All arithmetic is unsigned; the counter never wraps below 0.

Test Plan:
- Reset mid-SERVICE (cause=2, saved_pc=0x155) -> asynchronously pending=0, cause=0, saved_pc=0, in_service=0, mask=4'b1111, take=0.
- set_timer with timer_value=5 at cycle 0, pc_next=0x020 at cycle 5 -> pending[1] set after 5 IDLE cycles; take=1 next cycle; saved_pc=0x020, cause=2, in_service=1.
- halt and irq_in[2] edge in the same cycle, pc_next=0x07F -> first take cause=1, saved_pc=0x07F, pending=4'b0100; ack -> next IDLE cycle take with cause=3.
- mask=4'b1011, irq_in[2] edge -> pending=4'b0100, take=0; write mask=4'b1111 -> take=1 the following cycle, cause=3.
- In SERVICE, irq_in[3] held high 10 cycles and halt pulsed -> pending=4'b1001, take=0; ack -> cause=1 taken first, then cause=4 after a second ack.
- set_timer with timer_value=1 and set_timer with value 0 on the expiry edge -> no pending[1], counter=0; 50 further cycles -> take never asserted.
